// File: rtl/reg_write_queue_if.sv
// ---------------------------------------------------------------------------
// reg_write_queue_if
// Bundles the write-queue signals: request handshake (IN_*), drain control,
// the register-file write port (A3/WE3/WD3), the two read ports with their
// raw and forwarded data, and the occupancy status.
//   slave  : the view used by the queue itself
//   master : the view used by whatever drives requests and hosts the
//            register file (core pipeline or testbench)
// Parameters:
//   DEPTH  buffered entries (power of two, >= 2)
//   AW     register address width
//   DW     register data width
// ---------------------------------------------------------------------------
interface reg_write_queue_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  // request side
  logic          IN_VALID;
  logic          IN_READY;
  logic [AW-1:0] IN_ADDR;
  logic [DW-1:0] IN_DATA;

  // drain / register-file write port
  logic          DRAIN_EN;
  logic [AW-1:0] A3;
  logic          WE3;
  logic [DW-1:0] WD3;

  // read ports
  logic [AW-1:0] A1;
  logic [AW-1:0] A2;
  logic [DW-1:0] RF_RD1;
  logic [DW-1:0] RF_RD2;
  logic [DW-1:0] RD1;
  logic [DW-1:0] RD2;

  // status
  logic [CW-1:0] COUNT;
  logic          EMPTY;

  modport slave (
    input  IN_VALID, IN_ADDR, IN_DATA, DRAIN_EN, A1, A2, RF_RD1, RF_RD2,
    output IN_READY, A3, WE3, WD3, RD1, RD2, COUNT, EMPTY
  );

  modport master (
    output IN_VALID, IN_ADDR, IN_DATA, DRAIN_EN, A1, A2, RF_RD1, RF_RD2,
    input  IN_READY, A3, WE3, WD3, RD1, RD2, COUNT, EMPTY
  );
endinterface

// File: rtl/reg_write_queue.sv
// ---------------------------------------------------------------------------
// reg_write_queue
// Write-side initiator for the register file. Register writebacks are
// accepted on a valid/ready handshake, held in an in-order circular buffer
// of DEPTH entries, and drained one per cycle onto the write port
// (A3/WE3/WD3). While an entry is pending, its data is forwarded onto the
// read ports so consumers never observe a stale register value.
//
// Ports:
//   CLK    clock, all state changes on the rising edge
//   RESET  synchronous active-high reset; empties the queue and blocks WE3
//   bus    reg_write_queue_if.slave:
//            IN_VALID/IN_READY/IN_ADDR/IN_DATA  write request handshake
//            DRAIN_EN                           register file may be written
//            A3/WE3/WD3                         register file write port
//            A1/A2, RF_RD1/RF_RD2               read addresses, raw RF data
//            RD1/RD2                            forwarded read data
//            COUNT/EMPTY                        occupancy
// ---------------------------------------------------------------------------
module reg_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input logic               CLK,
  input logic               RESET,
  reg_write_queue_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // entry storage; contents are never cleared, validity comes from count_q
  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Ready looks only at occupancy, so a full queue refuses even when it is
  // popping this cycle; this keeps IN_READY free of any DRAIN_EN path.
  assign push = bus.IN_VALID & ~full;
  assign pop  = bus.WE3;

  // ------------------------------------------------------------------------
  // Drain side: the head entry is presented combinationally.
  // ------------------------------------------------------------------------
  assign bus.WE3   = ~empty & bus.DRAIN_EN & ~RESET;
  assign bus.A3    = empty ? '0 : addr_mem[head_q];
  assign bus.WD3   = empty ? '0 : data_mem[head_q];

  assign bus.IN_READY = ~full;
  assign bus.COUNT    = count_q;
  assign bus.EMPTY    = empty;

  // ------------------------------------------------------------------------
  // Pointer / count next state. DEPTH is a power of two so the pointers
  // wrap naturally at their width.
  // ------------------------------------------------------------------------
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (pop) begin
      head_d = head_q + PW'(1);
    end
    if (push) begin
      tail_d = tail_q + PW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage write. A write landing during reset is harmless because the
  // pointers and count are cleared on the same edge.
  always_ff @(posedge CLK) begin
    if (push) begin
      addr_mem[tail_q] <= bus.IN_ADDR;
      data_mem[tail_q] <= bus.IN_DATA;
    end
  end

  // ------------------------------------------------------------------------
  // Forwarding. Entries are examined by age: age 0 is the head (oldest),
  // age count-1 is the youngest. A later (younger) hit overrides an earlier
  // one, which gives "youngest matching entry wins". The head entry being
  // drained this cycle still counts, since the register file only updates
  // at the edge. The current IN_* request is not yet stored, so it is not
  // forwarded.
  // ------------------------------------------------------------------------
  logic [PW-1:0]    slot_of_age [DEPTH];
  logic [DEPTH-1:0] live;
  logic [DEPTH-1:0] hit1;
  logic [DEPTH-1:0] hit2;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_age
      assign slot_of_age[gi] = head_q + PW'(gi);
      assign live[gi]        = (CW'(gi) < count_q);
      assign hit1[gi]        = live[gi] && (addr_mem[slot_of_age[gi]] == bus.A1);
      assign hit2[gi]        = live[gi] && (addr_mem[slot_of_age[gi]] == bus.A2);
    end
  endgenerate

  logic [DW-1:0] rd1_fwd;
  logic [DW-1:0] rd2_fwd;

  always_comb begin
    rd1_fwd = bus.RF_RD1;
    rd2_fwd = bus.RF_RD2;
    for (int k = 0; k < DEPTH; k++) begin
      if (hit1[k]) begin
        rd1_fwd = data_mem[slot_of_age[k]];
      end
      if (hit2[k]) begin
        rd2_fwd = data_mem[slot_of_age[k]];
      end
    end
  end

  assign bus.RD1 = rd1_fwd;
  assign bus.RD2 = rd2_fwd;

endmodule

// File: doc/reg_write_queue.md
# reg_write_queue

Write-side initiator for the 32-bit register file. Accepts register writeback requests on a valid/ready handshake, buffers up to four in order, and drains one per cycle onto the register file write port (A3/WE3/WD3). It also forwards still-pending data onto the two read ports, so consumers never read a stale register while a write is queued.

## Interface
- DEPTH, 4, number of buffered write entries (power of two, ≥2)
- AW, 5, register address width (matches A1/A2/A3)
- DW, 32, data width (matches WD3/RD1/RD2)

- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- IN_VALID  in  1  write request present
- IN_READY  out  1  queue can accept; equals ~full
- IN_ADDR  in  AW  destination register
- IN_DATA  in  DW  write data
- DRAIN_EN  in  1  register file may be written this cycle
- A3  out  AW  register file write address
- WE3  out  1  register file write enable
- WD3  out  DW  register file write data
- A1, A2  in  AW  read addresses (shared with register file)
- RF_RD1, RF_RD2  in  DW  raw register file read data
- RD1, RD2  out  DW  forwarded read data to consumers
- COUNT  out  $clog2(DEPTH)+1  entries held
- EMPTY  out  1  COUNT==0

## Operation
- Storage: circular buffer of DEPTH entries {addr, data}, plus head pointer, tail pointer and count. Pointers wrap modulo DEPTH.
- Push: on an edge where IN_VALID & IN_READY, write {IN_ADDR, IN_DATA} at the tail, then tail+1.
  - IN_READY depends only on count (not on a same-cycle pop).
  - At full, IN_READY=0 and the request is held by the sender.
- Drain (combinational from head):
  - WE3 = ~EMPTY & DRAIN_EN & ~RESET.
  - A3/WD3 = head entry when ~EMPTY, else 0.
  - On an edge with WE3=1, the register file captures the write and the head advances (pop).
- Simultaneous push and pop: count unchanged, both pointers advance.
- Ordering: strict FIFO. No coalescing of same-address entries; every accepted write reaches the register file exactly once, in order.
- Forwarding: RD1 = data of the youngest valid entry whose addr==A1, else RF_RD1. RD2 uses the same rule with A2 and RF_RD2.
  - Scan runs from tail-1 back to head.
  - Address 0 is not special.
  - The head entry being written this cycle still forwards, because the register file updates only at the edge.
  - The IN_* request of the current cycle is not forwarded.
- RESET: head=tail=0, count=0, all pending entries discarded. Entry contents need not be cleared.

## Timing
- Reset values: IN_READY=1, WE3=0, A3=0, WD3=0, COUNT=0, EMPTY=1. RD1/RD2 pass through RF_RD1/RF_RD2.
- RESET asserted mid-operation: WE3 is forced to 0 in that same cycle (no partial drain). Queue is empty from the next cycle.
- Latency: a write accepted at edge N appears on WE3/A3/WD3 in cycle N+1 (if DRAIN_EN=1 and it is at the head). It lands in the register file at edge N+1.
- Forwarding of an entry is visible from cycle N+1 until the cycle after its pop edge. At that point the register file supplies the value.
- Throughput: one push and one pop per cycle sustained.
- DRAIN_EN=0 holds the queue. A3/WD3 still show the head entry, with WE3=0.
- Full: count==DEPTH, IN_READY=0. After a pop edge, IN_READY=1 next cycle.
- Empty: WE3=0 regardless of DRAIN_EN.

## Test plan
- Reset: drive garbage IN_*, RESET=1 for one edge → COUNT=0, EMPTY=1, IN_READY=1, WE3=0, A3=0, WD3=0.
- Single write: DRAIN_EN=1, push addr 3 / 0xDEADBEEF → next cycle WE3=1, A3=3, WD3=0xDEADBEEF. Cycle after: EMPTY=1, and the register file reg3 reads 0xDEADBEEF.
- Full/backpressure: DRAIN_EN=0, push five writes (addr 0..4, data 0x10..0x14) → four accepted, COUNT=4, IN_READY=0, fifth held. Raise DRAIN_EN → A3 sequence 0,1,2,3,4 on consecutive cycles; fifth accepted on the first cycle IN_READY returns.
- Forwarding: DRAIN_EN=0, push {2,0x11}, {2,0x22}, {7,0x77}:
  - A1=2 → RD1=0x22.
  - A2=7 → RD2=0x77.
  - A1=1 → RD1=RF_RD1.
  - Drain all → RD1 for A1=2 follows RF_RD1 (now 0x22).
- Simultaneous push/pop: COUNT=2, DRAIN_EN=1, IN_VALID=1 → COUNT stays 2 across 6 cycles, writes emerge in push order, including across pointer wrap.
- Reset mid-operation: COUNT=3, DRAIN_EN=1, RESET=1 → WE3=0 in the reset cycle. COUNT=0 next cycle; none of the three entries is ever written.
